// File: rtl/mem_data_stage_pkg.sv
// Shared encodings for the memory data stage and the downstream load mask.
// Holds the access-size codes, the sequencer state type and a size helper.
package mem_data_stage_pkg;

    localparam logic [1:0] CT_WORD = 2'b00;
    localparam logic [1:0] CT_HALF = 2'b01;
    localparam logic [1:0] CT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RD_WAIT = 2'b01,
        S_WRITE   = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    // Half and byte stores need a read-modify-write; 2'b11 behaves as a word.
    function automatic logic is_partial(input logic [1:0] ct);
        return (ct == CT_HALF) || (ct == CT_BYTE);
    endfunction

endpackage

// File: rtl/mem_data_stage_store_merge.sv
// Combinational merge of store data into a read word for partial stores.
// Low-bit placement mirrors the load mask; no lane steering by address.
module store_merge
    import mem_data_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    input  logic [1:0]  ct,
    output logic [31:0] merged
);

    always_comb begin
        merged = sdata;
        case (ct)
            CT_HALF: merged = {rdata[31:16], sdata[15:0]};
            CT_BYTE: merged = {rdata[31:8],  sdata[7:0]};
            default: merged = sdata;
        endcase
    end

endmodule

// File: rtl/mem_data_stage.sv
// Memory-access sequencer for lw/lh/lb/sw/sh/sb feeding the load mask.
// Partial stores are read-modify-write so memory only sees full-word writes.
module mem_data_stage
    import mem_data_stage_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_load,
    input  logic        start_store,
    input  logic [31:0] addr,
    input  logic [1:0]  ct,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_ct;
    logic [31:0]       r_sdata;
    logic              r_is_store;
    logic [31:0]       r_mdr;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       w_merged;

    store_merge u_store_merge (
        .rdata  (mem_rdata),
        .sdata  (r_sdata),
        .ct     (r_ct),
        .merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ct        <= CT_WORD;
            r_sdata     <= '0;
            r_is_store  <= 1'b0;
            r_mdr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Load takes priority; a simultaneous store is silently dropped.
                    if (start_load) begin
                        r_mem_addr <= addr;
                        r_ct       <= ct;
                        r_sdata    <= store_data;
                        r_is_store <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_RD_WAIT;
                    end else if (start_store) begin
                        r_mem_addr <= addr;
                        r_ct       <= ct;
                        r_sdata    <= store_data;
                        r_is_store <= 1'b1;
                        r_cnt      <= '0;
                        if (is_partial(ct)) begin
                            r_state <= S_RD_WAIT;
                        end else begin
                            r_mem_wdata <= store_data;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (r_is_store) begin
                            r_mem_wdata <= w_merged;
                            r_state     <= S_WRITE;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mdr       = r_mdr;
    assign mem_wr    = (r_state == S_WRITE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_data_stage.sv
// Directed bench for mem_data_stage: one instance at latency 1, one at latency 3.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mem_data_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load1, start_store1, start_load3, start_store3;
    logic [31:0] addr, store_data, mem_rdata;
    logic [1:0]  ct;

    logic [31:0] mem_addr1, mem_wdata1, mdr1;
    logic        mem_wr1, busy1, done1;
    logic [31:0] mem_addr3, mem_wdata3, mdr3;
    logic        mem_wr3, busy3, done3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_data_stage #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .start_load(start_load1), .start_store(start_store1),
        .addr(addr), .ct(ct), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
        .mdr(mdr1), .busy(busy1), .done(done1)
    );

    mem_data_stage #(.MEM_LATENCY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .start_load(start_load3), .start_store(start_store3),
        .addr(addr), .ct(ct), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
        .mdr(mdr3), .busy(busy3), .done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start_load1 = 1'b1; start_load3 = 1'b1;
        addr = 32'h40; ct = 2'b00; mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (mdr1 !== 32'h0) begin errors++; $display("FAIL reset_mdr cyc%0d got=%h exp=0", c, mdr1); end
            checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got=%b/%b exp=0/0", c, busy1, busy3); end
            checks++; if (done1 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL reset_done cyc%0d got=%b/%b exp=0/0", c, done1, done3); end
            checks++; if (mem_wr1 !== 1'b0 || mem_wr3 !== 1'b0) begin errors++; $display("FAIL reset_mem_wr cyc%0d got=%b/%b exp=0/0", c, mem_wr1, mem_wr3); end
            checks++; if (mem_addr1 !== 32'h0 || mem_wdata3 !== 32'h0) begin errors++; $display("FAIL reset_regs cyc%0d got=%h/%h exp=0/0", c, mem_addr1, mem_wdata3); end
        end
        start_load1 = 1'b0; start_load3 = 1'b0; reset = 1'b1;
        tick();
        checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_release_idle got=%b/%b exp=0/0", busy1, busy3); end
    endtask

    task automatic test_load_lat1();
        addr = 32'h40; ct = 2'b00; mem_rdata = 32'hDEAD_BEEF; start_load1 = 1'b1;
        tick();
        start_load1 = 1'b0; addr = 32'hFFFF_0000; ct = 2'b10;
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL load_cyc1 busy/done got=%b/%b exp=1/0", busy1, done1); end
        checks++; if (mem_addr1 !== 32'h40) begin errors++; $display("FAIL load_addr got=%h exp=00000040", mem_addr1); end
        checks++; if (mem_wr1 !== 1'b0) begin errors++; $display("FAIL load_no_wr1 got=%b exp=0", mem_wr1); end
        tick();
        checks++; if (done1 !== 1'b1 || mdr1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_done done/mdr got=%b/%h exp=1/deadbeef", done1, mdr1); end
        checks++; if (mem_wr1 !== 1'b0 || mem_addr1 !== 32'h40) begin errors++; $display("FAIL load_cyc2 wr/addr got=%b/%h exp=0/00000040", mem_wr1, mem_addr1); end
        tick();
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL load_end busy/done got=%b/%b exp=0/0", busy1, done1); end
    endtask

    task automatic test_word_store();
        addr = 32'h10; ct = 2'b00; store_data = 32'h1234_5678; mem_rdata = 32'h5555_5555;
        start_store1 = 1'b1;
        tick();
        start_store1 = 1'b0; store_data = 32'h0; addr = 32'h0;
        checks++; if (mem_wr1 !== 1'b1 || mem_wdata1 !== 32'h1234_5678) begin errors++; $display("FAIL wstore_write wr/wdata got=%b/%h exp=1/12345678", mem_wr1, mem_wdata1); end
        checks++; if (mem_addr1 !== 32'h10 || done1 !== 1'b0) begin errors++; $display("FAIL wstore_addr addr/done got=%h/%b exp=00000010/0", mem_addr1, done1); end
        tick();
        checks++; if (mem_wr1 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL wstore_done wr/done got=%b/%b exp=0/1", mem_wr1, done1); end
        checks++; if (mdr1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wstore_mdr got=%h exp=deadbeef", mdr1); end
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wstore_idle got=%b exp=0", busy1); end
    endtask

    task automatic test_partial_store();
        logic [1:0]  v_ct   [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] v_sd   [3] = '{32'h0000_0011, 32'h9999_EEFF, 32'hCAFE_F00D};
        logic [31:0] v_exp  [3] = '{32'hAABB_CC11, 32'hAABB_EEFF, 32'hCAFE_F00D};
        int          v_done [3] = '{5, 5, 2};
        for (int v = 0; v < 3; v++) begin
            int          wr_count = 0;
            int          done_cyc = -1;
            logic [31:0] wr_data  = 32'h0;
            mem_rdata = 32'hAABB_CCDD; addr = 32'h20 + 32'(v); ct = v_ct[v];
            store_data = v_sd[v]; start_store3 = 1'b1;
            tick();
            start_store3 = 1'b0; store_data = 32'h0; ct = 2'b00;
            for (int c = 1; c <= 8; c++) begin
                if (mem_wr3 === 1'b1) begin wr_count++; wr_data = mem_wdata3; end
                if (done3 === 1'b1 && done_cyc < 0) done_cyc = c;
                if (c < 8) tick();
            end
            checks++; if (wr_count !== 1) begin errors++; $display("FAIL pstore%0d_wr_count got=%0d exp=1", v, wr_count); end
            checks++; if (wr_data !== v_exp[v]) begin errors++; $display("FAIL pstore%0d_wdata got=%h exp=%h", v, wr_data, v_exp[v]); end
            checks++; if (done_cyc !== v_done[v]) begin errors++; $display("FAIL pstore%0d_latency got=%0d exp=%0d", v, done_cyc, v_done[v]); end
            checks++; if (mdr3 !== 32'h0 || busy3 !== 1'b0) begin errors++; $display("FAIL pstore%0d_mdr_idle mdr/busy got=%h/%b exp=0/0", v, mdr3, busy3); end
        end
    endtask

    task automatic test_simultaneous_and_late();
        int wr_count = 0;
        addr = 32'h44; ct = 2'b00; store_data = 32'h7777_7777; mem_rdata = 32'h1357_2468;
        start_load1 = 1'b1; start_store1 = 1'b1;
        tick();
        start_load1 = 1'b0; start_store1 = 1'b0;
        if (mem_wr1 === 1'b1) wr_count++;
        tick();
        if (mem_wr1 === 1'b1) wr_count++;
        checks++; if (done1 !== 1'b1 || mdr1 !== 32'h1357_2468) begin errors++; $display("FAIL both_load done/mdr got=%b/%h exp=1/13572468", done1, mdr1); end
        start_store1 = 1'b1;
        tick();
        start_store1 = 1'b0;
        if (mem_wr1 === 1'b1) wr_count++;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL late_store_busy got=%b exp=0", busy1); end
        tick();
        if (mem_wr1 === 1'b1) wr_count++;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL late_store_not_queued got=%b exp=0", busy1); end
        checks++; if (wr_count !== 0) begin errors++; $display("FAIL both_no_write got=%0d exp=0", wr_count); end
    endtask

    task automatic test_reset_midop();
        mem_rdata = 32'hAABB_CCDD; addr = 32'h80; ct = 2'b10; store_data = 32'h0000_0022;
        start_store3 = 1'b1;
        tick();
        start_store3 = 1'b0;
        repeat (3) tick();
        checks++; if (mem_wr3 !== 1'b1 || mem_wdata3 !== 32'hAABB_CC22) begin errors++; $display("FAIL midop_in_write wr/wdata got=%b/%h exp=1/aabbcc22", mem_wr3, mem_wdata3); end
        reset = 1'b0;
        tick();
        checks++; if (mem_wr3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL midop_abort wr/busy/done got=%b/%b/%b exp=0/0/0", mem_wr3, busy3, done3); end
        reset = 1'b1;
        tick();
        checks++; if (done3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL midop_no_done done/busy got=%b/%b exp=0/0", done3, busy3); end
        checks++; if (mem_addr3 !== 32'h0 || mem_wdata3 !== 32'h0) begin errors++; $display("FAIL midop_cleared addr/wdata got=%h/%h exp=0/0", mem_addr3, mem_wdata3); end
    endtask

    initial begin
        reset = 1'b0;
        start_load1 = 1'b0; start_store1 = 1'b0; start_load3 = 1'b0; start_store3 = 1'b0;
        addr = '0; ct = '0; store_data = '0; mem_rdata = '0;
        #2;
        test_reset();
        test_load_lat1();
        test_word_store();
        test_partial_store();
        test_simultaneous_and_late();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
